// File: rtl/tx_ppdu_framer.sv
// 802.11a PPDU framer: unscrambled SIGNAL, then scrambled SERVICE/PSDU/TAIL/PAD, one bit per output handshake.
// Optional macro TX_SEED_PORT_EN adds a per-frame scrambler seed port (zero seed falls back to SEED).
module tx_ppdu_framer #(
    parameter logic [6:0] SEED  = 7'b1011011,
    parameter int         LEN_W = 12
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       rate,
    input  logic [LEN_W-1:0] length,
`ifdef TX_SEED_PORT_EN
    input  logic [6:0]       seed,
`endif
    output logic             busy,
    output logic             err_rate,
    input  logic             in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_field,
    output logic             out_last
);
    localparam int CW = LEN_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SIGNAL, ST_SERVICE, ST_PSDU, ST_TAIL, ST_PAD, ST_DONE
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d, psdu_last;
    logic [7:0]       sym, sym_d, sym_inc, ndbps_q, ndbps_in;
    logic [6:0]       scr, scr_d, seed_val;
    logic [LEN_W-1:0] len_q;
    logic [23:0]      sig_q, sig_in;
    logic [11:0]      len12;
    logic             rate_ok, fb, load_slot, avail, nbit, nlast, accept;
    logic [1:0]       nfield;

    generate
        if (LEN_W >= 12) begin : g_len_trunc
            assign len12 = length[11:0];
        end else begin : g_len_ext
            assign len12 = {{(12-LEN_W){1'b0}}, length};
        end
    endgenerate

`ifdef TX_SEED_PORT_EN
    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            seed_val <= SEED;
        else if (accept)
            seed_val <= (seed == 7'd0) ? SEED : seed;
    end
`else
    assign seed_val = SEED;
`endif

    always_comb begin
        rate_ok  = 1'b1;
        ndbps_in = 8'd0;
        case (rate)
            4'b1101: ndbps_in = 8'd24;
            4'b1111: ndbps_in = 8'd36;
            4'b0101: ndbps_in = 8'd48;
            4'b0111: ndbps_in = 8'd72;
            4'b1001: ndbps_in = 8'd96;
            4'b1011: ndbps_in = 8'd144;
            4'b0001: ndbps_in = 8'd192;
            4'b0011: ndbps_in = 8'd216;
            default: rate_ok  = 1'b0;
        endcase
    end

    // SIGNAL bit i sits at sig_in[i]; transmission order is R1..R4 first.
    assign sig_in = {6'b000000, ^{rate, len12}, len12, 1'b0,
                     rate[0], rate[1], rate[2], rate[3]};

    assign busy      = (state != ST_IDLE);
    assign load_slot = !out_valid || out_ready;
    assign fb        = scr[6] ^ scr[3];
    assign sym_inc   = (sym == ndbps_q - 8'd1) ? 8'd0 : sym + 8'd1;
    assign psdu_last = {len_q, 3'b000} - {{(CW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sym_d    = sym;
        scr_d    = scr;
        avail    = 1'b0;
        nbit     = 1'b0;
        nfield   = 2'd0;
        nlast    = 1'b0;
        accept   = 1'b0;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && rate_ok) begin
                    accept  = 1'b1;
                    avail   = 1'b1;
                    nbit    = sig_in[0];
                    state_d = ST_SIGNAL;
                    cnt_d   = CW'(1);
                    sym_d   = 8'd0;
                end
            end
            ST_SIGNAL: begin
                avail = 1'b1;
                nbit  = sig_q[cnt[4:0]];
                if (load_slot) begin
                    if (cnt == CW'(23)) begin
                        state_d = ST_SERVICE;
                        cnt_d   = '0;
                        scr_d   = seed_val;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            ST_SERVICE: begin
                avail  = 1'b1;
                nbit   = fb;
                nfield = 2'd1;
                if (load_slot) begin
                    scr_d = {scr[5:0], fb};
                    sym_d = sym_inc;
                    if (cnt == CW'(15)) begin
                        cnt_d   = '0;
                        state_d = (len_q == '0) ? ST_TAIL : ST_PSDU;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            ST_PSDU: begin
                in_ready = load_slot;
                avail    = in_valid;
                nbit     = in_data ^ fb;
                nfield   = 2'd2;
                if (load_slot && in_valid) begin
                    scr_d = {scr[5:0], fb};
                    sym_d = sym_inc;
                    if (cnt == psdu_last) begin
                        cnt_d   = '0;
                        state_d = ST_TAIL;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            ST_TAIL: begin
                avail  = 1'b1;
                nfield = 2'd3;
                nlast  = (cnt == CW'(5)) && (sym_inc == 8'd0);
                if (load_slot) begin
                    scr_d = {scr[5:0], fb};
                    sym_d = sym_inc;
                    if (cnt == CW'(5)) begin
                        cnt_d   = '0;
                        state_d = (sym_inc == 8'd0) ? ST_DONE : ST_PAD;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            ST_PAD: begin
                avail  = 1'b1;
                nbit   = fb;
                nfield = 2'd3;
                nlast  = (sym_inc == 8'd0);
                if (load_slot) begin
                    scr_d = {scr[5:0], fb};
                    sym_d = sym_inc;
                    if (sym_inc == 8'd0)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (load_slot)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sym       <= 8'd0;
            scr       <= 7'd0;
            len_q     <= '0;
            ndbps_q   <= 8'd0;
            sig_q     <= 24'd0;
            err_rate  <= 1'b0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_field <= 2'd0;
            out_last  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sym      <= sym_d;
            scr      <= scr_d;
            err_rate <= (state == ST_IDLE) && start && !rate_ok;
            if (accept) begin
                len_q   <= length;
                ndbps_q <= ndbps_in;
                sig_q   <= sig_in;
            end
            // Output register refills only when empty or draining; otherwise it holds.
            if (load_slot) begin
                if (avail) begin
                    out_valid <= 1'b1;
                    out_data  <= nbit;
                    out_field <= nfield;
                    out_last  <= nlast;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tx_ppdu_framer.sv
// Bench for tx_ppdu_framer: random PSDUs and handshake gaps against a whole-frame reference model.
`timescale 1ns/1ps
module tb_tx_ppdu_framer;
    localparam logic [6:0] DEF_SEED = 7'b1011011;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  rate = 4'd0;
    logic [11:0] length = 12'd0;
`ifdef TX_SEED_PORT_EN
    logic [6:0]  seed = 7'd0;
    logic [6:0]  frame_seed = 7'd0;
`endif
    logic        busy, err_rate, in_ready, out_data, out_valid, out_last;
    logic        in_data = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  out_field;

    int          n_cmp = 0, n_bad = 0;
    logic [7:0]  psdu_mem [0:255];
    logic [3:0]  exp_q[$], got_q[$];
    int          first_cyc, consumed, stall_viol;
    bit          timed_out;

    always #5 Clk = ~Clk;

    tx_ppdu_framer dut (
        .Clk(Clk), .reset(reset), .start(start), .rate(rate), .length(length),
`ifdef TX_SEED_PORT_EN
        .seed(seed),
`endif
        .busy(busy), .err_rate(err_rate),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_field(out_field), .out_last(out_last)
    );

    function automatic int ndbps_of(input logic [3:0] r);
        case (r)
            4'b1101: return 24;
            4'b1111: return 36;
            4'b0101: return 48;
            4'b0111: return 72;
            4'b1001: return 96;
            4'b1011: return 144;
            4'b0001: return 192;
            4'b0011: return 216;
            default: return 0;
        endcase
    endfunction

    // Whole frame as {last, field, bit}: padded up to whole OFDM symbols, scrambled, tail zeroed.
    task automatic build_model(input logic [3:0] r, input int len);
        logic [6:0] s;
        logic       b, f_b;
        logic [1:0] f;
        int         par, nd, ndata, npad;
        exp_q.delete();
        par = 0;
        for (int i = 0; i < 4; i++) begin
            b = r[3-i];
            par += int'(b);
            exp_q.push_back({3'b000, b});
        end
        exp_q.push_back(4'b0000);
        for (int i = 0; i < 12; i++) begin
            b = len[i];
            par += int'(b);
            exp_q.push_back({3'b000, b});
        end
        exp_q.push_back({3'b000, par[0]});
        for (int i = 0; i < 6; i++) exp_q.push_back(4'b0000);
        nd    = ndbps_of(r);
        ndata = 16 + 8*len + 6;
        npad  = ((ndata + nd - 1) / nd) * nd - ndata;
`ifdef TX_SEED_PORT_EN
        s = (frame_seed == 7'd0) ? DEF_SEED : frame_seed;
`else
        s = DEF_SEED;
`endif
        for (int i = 0; i < ndata + npad; i++) begin
            if (i < 16) begin
                b = 1'b0; f = 2'd1;
            end else if (i < 16 + 8*len) begin
                b = psdu_mem[(i-16)/8][(i-16)%8]; f = 2'd2;
            end else begin
                b = 1'b0; f = 2'd3;
            end
            f_b = s[6] ^ s[3];
            s   = {s[5:0], f_b};
            b   = b ^ f_b;
            if (i >= 16 + 8*len && i < ndata) b = 1'b0;
            exp_q.push_back({(i == ndata + npad - 1), f, b});
        end
    endtask

    // Drives one frame and collects accepted output bits; no checking here.
    task automatic run_frame(input logic [3:0] r, input int len, input int rdy_pct,
                             input int vld_pct, input int abort_at, input int restart_at);
        logic       hold_v;
        logic [3:0] held;
        bit         restarted, done;
        int         cyc;
        got_q.delete();
        consumed = 0; stall_viol = 0; timed_out = 0; first_cyc = -1;
        hold_v = 1'b0; held = 4'd0; restarted = 0; done = 0;
        @(negedge Clk);
        start = 1'b1; rate = r; length = 12'(len);
`ifdef TX_SEED_PORT_EN
        seed = frame_seed;
`endif
        @(negedge Clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20000) begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            in_valid  = ($urandom_range(0, 99) < vld_pct);
            in_data   = (consumed < 8*len) ? psdu_mem[consumed/8][consumed%8] : 1'b0;
            if (!restarted && restart_at >= 0 && int'(got_q.size()) >= restart_at) begin
                start = 1'b1; rate = 4'b0011; length = 12'd50; restarted = 1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (abort_at >= 0 && consumed == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                return;
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (hold_v && (!out_valid || {out_last, out_field, out_data} !== held))
                stall_viol++;
            if (in_valid && in_ready) consumed++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_field, out_data});
                if (out_last) done = 1;
            end
            hold_v = out_valid && !out_ready;
            held   = {out_last, out_field, out_data};
            @(negedge Clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        timed_out = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({busy, err_rate, in_ready, out_data, out_valid, out_field, out_last} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_in got %b want 00000000",
                     {busy, err_rate, in_ready, out_data, out_valid, out_field, out_last});
        end
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({busy, err_rate, in_ready, out_valid, out_last} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_idle got %b want 00000", {busy, err_rate, in_ready, out_valid, out_last});
        end
    endtask

    task automatic test_basic();
        logic [23:0] sig_obs;
        logic [15:0] svc_obs;
        psdu_mem[0] = 8'h00;
`ifdef TX_SEED_PORT_EN
        frame_seed = 7'h7F;
`endif
        build_model(4'b1101, 1);
        run_frame(4'b1101, 1, 100, 100, -1, -1);
        n_cmp++;
        if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
        n_cmp++;
        if (got_q.size() !== 72) begin n_bad++; $display("FAIL basic_len got %0d want 72", got_q.size()); end
        n_cmp++;
        if (first_cyc !== 0) begin n_bad++; $display("FAIL basic_first_cycle got %0d want 0", first_cyc); end
        sig_obs = 24'd0;
        svc_obs = 16'd0;
        for (int i = 0; i < 24 && i < int'(got_q.size()); i++) sig_obs[23-i] = got_q[i][0];
        for (int i = 0; i < 16 && i + 24 < int'(got_q.size()); i++) svc_obs[15-i] = got_q[i+24][0];
        n_cmp++;
        if (sig_obs !== 24'b1101_0_100000000000_0_000000) begin
            n_bad++; $display("FAIL basic_signal got %b want 110101000000000000000000", sig_obs);
        end
`ifdef TX_SEED_PORT_EN
        n_cmp++;
        if (svc_obs !== 16'b0000111011110010) begin
            n_bad++; $display("FAIL basic_service got %b want 0000111011110010", svc_obs);
        end
`endif
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            n_cmp++;
            if ((i < int'(got_q.size()) ? got_q[i] : 4'bxxxx) !== exp_q[i]) begin
                n_bad++; $display("FAIL basic_bit %0d got %b want %b", i,
                                  (i < int'(got_q.size()) ? got_q[i] : 4'bxxxx), exp_q[i]);
            end
        end
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin n_bad++; $display("FAIL basic_idle got %b want 00", {busy, out_valid}); end
    endtask

    task automatic test_rate54();
        int n3;
        for (int i = 0; i < 100; i++) psdu_mem[i] = 8'($urandom);
`ifdef TX_SEED_PORT_EN
        frame_seed = 7'($urandom_range(0, 127));
`endif
        build_model(4'b0011, 100);
        run_frame(4'b0011, 100, 100, 100, -1, -1);
        n_cmp++;
        if (got_q.size() !== 888) begin n_bad++; $display("FAIL r54_len got %0d want 888", got_q.size()); end
        n3 = 0;
        foreach (got_q[i]) if (got_q[i][2:1] == 2'd3) n3++;
        n_cmp++;
        if (n3 !== 48) begin n_bad++; $display("FAIL r54_tailpad_count got %0d want 48", n3); end
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            n_cmp++;
            if ((i < int'(got_q.size()) ? got_q[i] : 4'bxxxx) !== exp_q[i]) begin
                n_bad++; $display("FAIL r54_bit %0d got %b want %b", i,
                                  (i < int'(got_q.size()) ? got_q[i] : 4'bxxxx), exp_q[i]);
            end
        end
    endtask

    task automatic test_err_rate();
        int seen;
        @(negedge Clk);
        start = 1'b1; rate = 4'b0000; length = 12'd5;
        @(negedge Clk);
        start = 1'b0;
        n_cmp++;
        if ({err_rate, busy, out_valid} !== 3'b100) begin
            n_bad++; $display("FAIL err_pulse got %b want 100", {err_rate, busy, out_valid});
        end
        seen = 0;
        repeat (6) begin
            @(negedge Clk);
            if (err_rate || busy || out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL err_quiet got %0d active cycles want 0", seen); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) psdu_mem[i] = 8'($urandom);
`ifdef TX_SEED_PORT_EN
        frame_seed = 7'($urandom_range(0, 127));
`endif
        build_model(4'b1011, 8);
        run_frame(4'b1011, 8, 50, 60, -1, -1);
        n_cmp++;
        if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
        n_cmp++;
        if (stall_viol !== 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
        n_cmp++;
        if (consumed !== 64) begin n_bad++; $display("FAIL bp_consumed got %0d want 64", consumed); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            n_cmp++;
            if ((i < int'(got_q.size()) ? got_q[i] : 4'bxxxx) !== exp_q[i]) begin
                n_bad++; $display("FAIL bp_bit %0d got %b want %b", i,
                                  (i < int'(got_q.size()) ? got_q[i] : 4'bxxxx), exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) psdu_mem[i] = 8'($urandom);
        run_frame(4'b1101, 8, 100, 100, 30, -1);
        n_cmp++;
        if (consumed !== 30) begin n_bad++; $display("FAIL mid_abort_point got %0d want 30", consumed); end
        #1;
        n_cmp++;
        if ({out_valid, in_ready, busy, out_last, err_rate} !== 5'b00000) begin
            n_bad++; $display("FAIL mid_reset_outputs got %b want 00000",
                              {out_valid, in_ready, busy, out_last, err_rate});
        end
        @(negedge Clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) psdu_mem[i] = 8'($urandom);
`ifdef TX_SEED_PORT_EN
        frame_seed = 7'd0;
`endif
        build_model(4'b1101, 2);
        run_frame(4'b1101, 2, 100, 100, -1, -1);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL mid_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            n_cmp++;
            if ((i < int'(got_q.size()) ? got_q[i] : 4'bxxxx) !== exp_q[i]) begin
                n_bad++; $display("FAIL mid_bit %0d got %b want %b", i,
                                  (i < int'(got_q.size()) ? got_q[i] : 4'bxxxx), exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int seen;
        for (int i = 0; i < 3; i++) psdu_mem[i] = 8'($urandom);
`ifdef TX_SEED_PORT_EN
        frame_seed = 7'($urandom_range(1, 127));
`endif
        build_model(4'b1101, 3);
        run_frame(4'b1101, 3, 100, 100, -1, 10);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL busy_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            n_cmp++;
            if ((i < int'(got_q.size()) ? got_q[i] : 4'bxxxx) !== exp_q[i]) begin
                n_bad++; $display("FAIL busy_bit %0d got %b want %b", i,
                                  (i < int'(got_q.size()) ? got_q[i] : 4'bxxxx), exp_q[i]);
            end
        end
        seen = 0;
        repeat (8) begin
            @(negedge Clk);
            if (busy || out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL busy_no_restart got %0d active cycles want 0", seen); end
    endtask

    task automatic test_zero_length();
`ifdef TX_SEED_PORT_EN
        frame_seed = 7'($urandom_range(0, 127));
`endif
        build_model(4'b0001, 0);
        run_frame(4'b0001, 0, 70, 100, -1, -1);
        n_cmp++;
        if (got_q.size() !== 216) begin n_bad++; $display("FAIL zero_len got %0d want 216", got_q.size()); end
        n_cmp++;
        if (consumed !== 0) begin n_bad++; $display("FAIL zero_consumed got %0d want 0", consumed); end
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            n_cmp++;
            if ((i < int'(got_q.size()) ? got_q[i] : 4'bxxxx) !== exp_q[i]) begin
                n_bad++; $display("FAIL zero_bit %0d got %b want %b", i,
                                  (i < int'(got_q.size()) ? got_q[i] : 4'bxxxx), exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rate54();
        test_err_rate();
        test_backpressure();
        test_reset_mid();
        test_start_while_busy();
        test_zero_length();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
